// File: rtl/simon_button_input_if.sv
// Button-input bundle between the raw button pads and the Simon game core.
// The master side is the conditioning block; the slave side is its consumer.
interface simon_button_input_if;
    logic [3:0] btn;
    logic       enable;
    logic [1:0] playerNum;
    logic       playerPressed;
    logic       multiPress;
    logic [3:0] btnStable;

    modport master (
        input  btn,
        input  enable,
        output playerNum,
        output playerPressed,
        output multiPress,
        output btnStable
    );

    modport slave (
        output btn,
        output enable,
        input  playerNum,
        input  playerPressed,
        input  multiPress,
        input  btnStable
    );
endinterface

// File: rtl/simon_button_input.sv
// Synchronise, debounce and encode the four Simon colour buttons into
// one clean press/release pulse per physical press, gated to the player's turn.
module simon_button_input #(
    parameter int DEBOUNCE_TICKS = 3
) (
    input logic                  clk,
    input logic                  reset,
    simon_button_input_if.master bus
);
    localparam logic [3:0] LAST = 4'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        WAIT_CLEAR
    } state_t;

    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] stable;
    logic [3:0] cnt [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            s1 <= bus.btn;
            s2 <= s1;
            // any cycle of agreement restarts the count
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    logic [1:0] idx;
    logic       one;
    logic       many;

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (stable[i]) idx = 2'(i);
        end
        one  = $onehot(stable);
        many = (stable != 4'd0) && !one;
    end

    state_t     state_q;
    state_t     state_d;
    logic [1:0] num_q;
    logic [1:0] num_d;
    logic       pressed_q;
    logic       pressed_d;
    logic       multi_q;
    logic       multi_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            num_q     <= 2'd0;
            pressed_q <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            pressed_q <= pressed_d;
            multi_q   <= multi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        pressed_d = pressed_q;
        multi_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                pressed_d = 1'b0;
                if (bus.enable && one) begin
                    num_d     = idx;
                    pressed_d = 1'b1;
                    state_d   = HELD;
                end else if (bus.enable && many) begin
                    multi_d = 1'b1;
                    state_d = WAIT_CLEAR;
                end
            end
            // enable is ignored here so a press is never cut short
            HELD: begin
                if (!stable[num_q]) begin
                    pressed_d = 1'b0;
                    state_d   = (stable == 4'd0) ? IDLE : WAIT_CLEAR;
                end
            end
            WAIT_CLEAR: begin
                pressed_d = 1'b0;
                if (stable == 4'd0) state_d = IDLE;
            end
            default: begin
                pressed_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    assign bus.playerNum     = num_q;
    assign bus.playerPressed = pressed_q;
    assign bus.multiPress    = multi_q;
    assign bus.btnStable     = stable;
endmodule

// File: tb/tb_simon_button_input.sv
// Scoreboard bench for simon_button_input: stimulus pushes expected
// press/release/reject events, a monitor pops them as the outputs move.
module tb_simon_button_input;
    localparam int EV_PRESS = 0;
    localparam int EV_REL   = 1;
    localparam int EV_MULTI = 2;

    typedef struct {
        int kind;
        int num;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_on = 1'b0;
    logic prev_pressed = 1'b0;
    ev_t  sb [$];

    simon_button_input_if b ();

    simon_button_input #(.DEBOUNCE_TICKS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int kind, input int num, input int c);
        ev_t e;
        e.kind = kind;
        e.num  = num;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event kind=%0d num=%0d cyc=%0d, none expected",
                     kind, b.playerNum, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || (e.num >= 0 && e.num != int'(b.playerNum)) ||
                (e.cyc >= 0 && e.cyc != cyc)) begin
                miscompares++;
                $display("FAIL event got kind=%0d num=%0d cyc=%0d, want kind=%0d num=%0d cyc=%0d",
                         kind, b.playerNum, cyc, e.kind, e.num, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (b.playerPressed && !prev_pressed) observe(EV_PRESS);
            if (!b.playerPressed && prev_pressed) observe(EV_REL);
            if (b.multiPress) observe(EV_MULTI);
            prev_pressed <= b.playerPressed;
        end
    end

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int bounce [8] = '{1, 0, 1, 1, 0, 1, 1, 1};

    initial begin
        int last_rise;
        int prev;
        int waited;
        b.btn    = 4'd0;
        b.enable = 1'b0;
        reset    = 1'b1;
        tick(3);
        check("reset_pressed", int'(b.playerPressed), 0);
        check("reset_num", int'(b.playerNum), 0);
        check("reset_multi", int'(b.multiPress), 0);
        check("reset_stable", int'(b.btnStable), 0);
        reset  = 1'b0;
        mon_on = 1'b1;

        // clean press of colour 2
        b.enable = 1'b1;
        b.btn    = 4'b0100;
        push(EV_PRESS, 2, cyc + 6);
        tick(4);
        check("clean_stable_early", int'(b.btnStable), 0);
        tick(1);
        check("clean_stable", int'(b.btnStable), 4);
        tick(15);
        b.btn = 4'b0000;
        push(EV_REL, 2, cyc + 6);
        tick(10);
        check("clean_num_hold", int'(b.playerNum), 2);

        // bouncy press of colour 1
        prev      = 0;
        last_rise = 0;
        for (int i = 0; i < 8; i++) begin
            b.btn = {2'b00, bounce[i][0], 1'b0};
            if (bounce[i] == 1 && prev == 0) last_rise = cyc;
            prev = bounce[i];
            check("bounce_no_glitch", int'(b.btnStable), 0);
            tick(1);
        end
        push(EV_PRESS, 1, last_rise + 6);
        tick(10);
        b.btn = 4'b0000;
        push(EV_REL, 1, cyc + 6);
        tick(10);

        // gated press of colour 3, accepted when enable rises
        b.enable = 1'b0;
        b.btn    = 4'b1000;
        tick(10);
        check("gate_stable", int'(b.btnStable), 8);
        check("gate_pressed", int'(b.playerPressed), 0);
        b.enable = 1'b1;
        push(EV_PRESS, 3, cyc + 1);
        tick(3);
        b.btn = 4'b0000;
        push(EV_REL, 3, cyc + 6);
        tick(10);

        // simultaneous colours 0 and 1 are rejected
        b.btn = 4'b0011;
        push(EV_MULTI, -1, cyc + 6);
        tick(10);
        b.btn = 4'b0010;
        tick(10);
        b.btn = 4'b0000;
        tick(10);
        b.btn = 4'b0100;
        push(EV_PRESS, 2, cyc + 6);
        tick(10);
        b.btn = 4'b0000;
        push(EV_REL, 2, cyc + 6);
        tick(10);

        // rolling press: 0 then 3, release 0 first
        b.btn = 4'b0001;
        push(EV_PRESS, 0, cyc + 6);
        tick(10);
        b.btn = 4'b1001;
        tick(10);
        b.btn = 4'b1000;
        push(EV_REL, 0, cyc + 6);
        tick(10);
        check("roll_num_hold", int'(b.playerNum), 0);
        b.btn = 4'b0000;
        tick(10);
        b.btn = 4'b1000;
        push(EV_PRESS, 3, cyc + 6);
        tick(10);
        b.btn = 4'b0000;
        push(EV_REL, 3, cyc + 6);
        tick(10);

        // reset while colour 2 is held
        b.btn = 4'b0100;
        push(EV_PRESS, 2, cyc + 6);
        tick(10);
        reset = 1'b1;
        push(EV_REL, 0, cyc + 1);
        push(EV_PRESS, 2, -1);
        tick(1);
        reset = 1'b0;
        check("rst_stable", int'(b.btnStable), 0);
        tick(12);
        b.btn = 4'b0000;
        push(EV_REL, 2, cyc + 6);

        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            tick(1);
            waited++;
        end
        while (sb.size() != 0) begin
            ev_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event got=none want kind=%0d num=%0d cyc=%0d",
                     e.kind, e.num, e.cyc);
        end
        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
